// File: rtl/tx_mac_sched.sv
// tx_mac_sched: two-requester round-robin packet scheduler for the 10G MAC
// TX interface (clk156 domain).
//
// Each requester is a first-word-fall-through packet queue plus a
// packet-available level. A winner is picked per packet, the tx_start/tx_ack
// handshake with the MAC is run, and the packet is streamed word by word.
// A programmable idle gap follows every eop word.
//
// Ports:
//   clk156, reset        clock, synchronous active-high reset
//   reqN_pkt_avail       at least one complete packet queued in requester N
//   reqN_data/len/eop    FWFT head word, byte-count code, last-word flag
//   reqN_rd_en           pop head word of requester N
//   reqN_pkt_ack         one-cycle pulse, packet taken (pop packet-info entry)
//   tx_data              granted requester head data
//   tx_data_valid        byte enables, 0x00 unless a word is being sent
//   tx_start             packet start request to MAC
//   tx_ack               MAC accepts first word
//   grant_id             requester owning the current or most recent packet
//   tx_pkt_count         packets completed, wraps modulo 2^32
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no packet committed; arbitrate, raise tx_start and pkt_ack
// WAIT_ACK | packet committed, waiting for MAC tx_ack (first word sent on ack)
// SEND     | streaming remaining words, one per cycle, until eop
// IFG      | inter-frame idle gap, counts down from IFG_CYCLES
module tx_mac_sched #(
    parameter int unsigned IFG_CYCLES = 1
) (
    input  logic        clk156,
    input  logic        reset,
    input  logic        req0_pkt_avail,
    input  logic [63:0] req0_data,
    input  logic [3:0]  req0_len,
    input  logic        req0_eop,
    output logic        req0_rd_en,
    output logic        req0_pkt_ack,
    input  logic        req1_pkt_avail,
    input  logic [63:0] req1_data,
    input  logic [3:0]  req1_len,
    input  logic        req1_eop,
    output logic        req1_rd_en,
    output logic        req1_pkt_ack,
    output logic [63:0] tx_data,
    output logic [7:0]  tx_data_valid,
    output logic        tx_start,
    input  logic        tx_ack,
    output logic        grant_id,
    output logic [31:0] tx_pkt_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        SEND     = 2'd2,
        IFG      = 2'd3
    } state_t;

    localparam logic [7:0] IFG_LOAD = 8'(IFG_CYCLES);

    state_t      state, state_nxt;
    logic [7:0]  ifg_cnt, ifg_cnt_nxt;
    logic [31:0] pkt_count_nxt;
    logic        grant_nxt;
    logic        winner;
    logic        send_word;
    logic [3:0]  head_len;
    logic        head_eop;

    // Codes 0..7 enable that many bytes plus one, LSB-aligned; codes 8..15
    // enable nothing but the word is still consumed.
    function automatic logic [7:0] len_mask(input logic [3:0] code);
        if (code[3])
            return 8'h00;
        else
            return 8'hFF >> (3'd7 - code[2:0]);
    endfunction

    assign tx_data  = grant_id ? req1_data : req0_data;
    assign head_len = grant_id ? req1_len  : req0_len;
    assign head_eop = grant_id ? req1_eop  : req0_eop;

    always_ff @(posedge clk156) begin
        if (reset) begin
            state        <= IDLE;
            ifg_cnt      <= 8'd0;
            grant_id     <= 1'b1;
            tx_pkt_count <= 32'd0;
        end else begin
            state        <= state_nxt;
            ifg_cnt      <= ifg_cnt_nxt;
            grant_id     <= grant_nxt;
            tx_pkt_count <= pkt_count_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ifg_cnt_nxt   = ifg_cnt;
        grant_nxt     = grant_id;
        pkt_count_nxt = tx_pkt_count;
        winner        = 1'b0;
        send_word     = 1'b0;
        tx_start      = 1'b0;
        tx_data_valid = 8'h00;
        req0_rd_en    = 1'b0;
        req1_rd_en    = 1'b0;
        req0_pkt_ack  = 1'b0;
        req1_pkt_ack  = 1'b0;

        // Outputs held quiet while reset is asserted so nothing is popped
        // from requesters that are being reset alongside this block.
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (req0_pkt_avail || req1_pkt_avail) begin
                        // Contention goes to the requester that did not own
                        // the previous packet.
                        winner = (req0_pkt_avail && req1_pkt_avail) ? ~grant_id
                                                                    : req1_pkt_avail;
                        tx_start     = 1'b1;
                        req0_pkt_ack = ~winner;
                        req1_pkt_ack = winner;
                        grant_nxt    = winner;
                        state_nxt    = WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    send_word = tx_ack;
                end
                SEND: begin
                    send_word = 1'b1;
                end
                IFG: begin
                    ifg_cnt_nxt = ifg_cnt - 8'd1;
                    if (ifg_cnt <= 8'd1)
                        state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase

            if (send_word) begin
                tx_data_valid = len_mask(head_len);
                req0_rd_en    = ~grant_id;
                req1_rd_en    = grant_id;
                if (head_eop) begin
                    pkt_count_nxt = tx_pkt_count + 32'd1;
                    ifg_cnt_nxt   = IFG_LOAD;
                    state_nxt     = (IFG_LOAD == 8'd0) ? IDLE : IFG;
                end else begin
                    state_nxt = SEND;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_mac_sched.sv
module tb_tx_mac_sched;

    localparam int IFG = 1;
    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;

    logic        clk156 = 1'b0;
    logic        reset = 1'b1;
    logic        req0_pkt_avail = 0, req1_pkt_avail = 0;
    logic [63:0] req0_data = 0, req1_data = 0;
    logic [3:0]  req0_len = 0, req1_len = 0;
    logic        req0_eop = 0, req1_eop = 0;
    logic        tx_ack = 0;

    logic        req0_rd_en, req1_rd_en, req0_pkt_ack, req1_pkt_ack;
    logic [63:0] tx_data;
    logic [7:0]  tx_data_valid;
    logic        tx_start, grant_id;
    logic [31:0] tx_pkt_count;

    logic        g0_rd0, g0_rd1, g0_pa0, g0_pa1, g0_start, g0_gid;
    logic [63:0] g0_data;
    logic [7:0]  g0_dv;
    logic [31:0] g0_cnt;
    logic        g3_rd0, g3_rd1, g3_pa0, g3_pa1, g3_start, g3_gid;
    logic [63:0] g3_data;
    logic [7:0]  g3_dv;
    logic [31:0] g3_cnt;

    always #5 clk156 = ~clk156;

    tx_mac_sched #(.IFG_CYCLES(IFG)) dut (
        .clk156(clk156), .reset(reset),
        .req0_pkt_avail(req0_pkt_avail), .req0_data(req0_data), .req0_len(req0_len),
        .req0_eop(req0_eop), .req0_rd_en(req0_rd_en), .req0_pkt_ack(req0_pkt_ack),
        .req1_pkt_avail(req1_pkt_avail), .req1_data(req1_data), .req1_len(req1_len),
        .req1_eop(req1_eop), .req1_rd_en(req1_rd_en), .req1_pkt_ack(req1_pkt_ack),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_start(tx_start),
        .tx_ack(tx_ack), .grant_id(grant_id), .tx_pkt_count(tx_pkt_count)
    );

    tx_mac_sched #(.IFG_CYCLES(0)) dut_g0 (
        .clk156(clk156), .reset(reset),
        .req0_pkt_avail(req0_pkt_avail), .req0_data(req0_data), .req0_len(req0_len),
        .req0_eop(req0_eop), .req0_rd_en(g0_rd0), .req0_pkt_ack(g0_pa0),
        .req1_pkt_avail(req1_pkt_avail), .req1_data(req1_data), .req1_len(req1_len),
        .req1_eop(req1_eop), .req1_rd_en(g0_rd1), .req1_pkt_ack(g0_pa1),
        .tx_data(g0_data), .tx_data_valid(g0_dv), .tx_start(g0_start),
        .tx_ack(tx_ack), .grant_id(g0_gid), .tx_pkt_count(g0_cnt)
    );

    tx_mac_sched #(.IFG_CYCLES(3)) dut_g3 (
        .clk156(clk156), .reset(reset),
        .req0_pkt_avail(req0_pkt_avail), .req0_data(req0_data), .req0_len(req0_len),
        .req0_eop(req0_eop), .req0_rd_en(g3_rd0), .req0_pkt_ack(g3_pa0),
        .req1_pkt_avail(req1_pkt_avail), .req1_data(req1_data), .req1_len(req1_len),
        .req1_eop(req1_eop), .req1_rd_en(g3_rd1), .req1_pkt_ack(g3_pa1),
        .tx_data(g3_data), .tx_data_valid(g3_dv), .tx_start(g3_start),
        .tx_ack(tx_ack), .grant_id(g3_gid), .tx_pkt_count(g3_cnt)
    );

    int vec_count = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk156);
        #1;
    endtask

    // Byte-enable mask from the length rule: n+1 low bytes for codes 0..7.
    function automatic logic [7:0] model_mask(input logic [3:0] code);
        int n;
        n = int'(code);
        if (n < 8)
            return 8'((1 << (n + 1)) - 1);
        return 8'h00;
    endfunction

    // Requester FIFO models: word queues plus count of packet-info entries.
    typedef struct packed {
        logic [63:0] d;
        logic [3:0]  l;
        logic        e;
    } word_t;

    word_t q0[$];
    word_t q1[$];
    int    np0 = 0, np1 = 0;

    task automatic push_pkt(input int r);
        int    n;
        word_t w;
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) begin
            w.d = {$urandom, $urandom};
            w.l = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15))
                                              : 4'($urandom_range(0, 7));
            w.e = (i == n - 1);
            if (r == 0) q0.push_back(w); else q1.push_back(w);
        end
        if (r == 0) np0++; else np1++;
    endtask

    task automatic drive_heads();
        req0_pkt_avail = (np0 > 0);
        req1_pkt_avail = (np1 > 0);
        if (q0.size() > 0) begin
            req0_data = q0[0].d; req0_len = q0[0].l; req0_eop = q0[0].e;
        end else begin
            req0_data = '0; req0_len = '0; req0_eop = 1'b0;
        end
        if (q1.size() > 0) begin
            req1_data = q1[0].d; req1_len = q1[0].l; req1_eop = q1[0].e;
        end else begin
            req1_data = '0; req1_len = '0; req1_eop = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_pkt_avail = 0; req1_pkt_avail = 0; tx_ack = 0;
        req0_data = '0; req1_data = '0; req0_len = '0; req1_len = '0;
        req0_eop = 0; req1_eop = 0;
        q0.delete(); q1.delete(); np0 = 0; np1 = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct packed {
        logic        a0, a1;
        logic [3:0]  l0;
        logic        e0, ack;
        logic        st, pa0, pa1, rd0, rd1;
        logic [7:0]  dv;
        logic        gid;
        logic [31:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic a0, a1, input logic [3:0] l0, input logic e0, ack,
                                input logic st, pa0, pa1, rd0, rd1, input logic [7:0] dv,
                                input logic gid, input logic [31:0] cnt);
        vec_t v;
        v.a0 = a0; v.a1 = a1; v.l0 = l0; v.e0 = e0; v.ack = ack;
        v.st = st; v.pa0 = pa0; v.pa1 = pa1; v.rd0 = rd0; v.rd1 = rd1;
        v.dv = dv; v.gid = gid; v.cnt = cnt;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        vec_t  v;
        word_t hw;
        logic  [7:0] dmask [4];
        logic  busy, acked, mgid, exp_st, win, s_rd0, s_rd1, s_pa0, s_pa1;
        int    mcnt, next_ok;

        //          a0 a1 l0 e0 ack  st pa0 pa1 rd0 rd1 dv     gid cnt
        tbl.push_back(mk(0, 0, 4'd3, 1, 0,  0, 0, 0, 0, 0, 8'h00, 1, 0)); // reset state
        tbl.push_back(mk(1, 0, 4'd3, 1, 0,  1, 1, 0, 0, 0, 8'h00, 1, 0)); // start req0
        tbl.push_back(mk(0, 0, 4'd3, 1, 1,  0, 0, 0, 1, 0, 8'h0F, 0, 0)); // ack, single word
        tbl.push_back(mk(0, 0, 4'd3, 1, 0,  0, 0, 0, 0, 0, 8'h00, 0, 1)); // IFG
        tbl.push_back(mk(0, 0, 4'd3, 1, 1,  0, 0, 0, 0, 0, 8'h00, 0, 1)); // idle, stray ack
        tbl.push_back(mk(1, 1, 4'd3, 1, 0,  1, 0, 1, 0, 0, 8'h00, 0, 1)); // both -> req1
        tbl.push_back(mk(1, 0, 4'd3, 1, 0,  0, 0, 0, 0, 0, 8'h00, 1, 1)); // wait ack
        tbl.push_back(mk(1, 0, 4'd3, 1, 1,  0, 0, 0, 0, 1, 8'hFF, 1, 1)); // req1 word
        tbl.push_back(mk(1, 0, 4'd3, 1, 0,  0, 0, 0, 0, 0, 8'h00, 1, 2)); // IFG blocks start
        tbl.push_back(mk(1, 0, 4'd0, 0, 0,  1, 1, 0, 0, 0, 8'h00, 1, 2)); // start req0
        tbl.push_back(mk(0, 0, 4'd0, 0, 1,  0, 0, 0, 1, 0, 8'h01, 0, 2)); // len 0
        tbl.push_back(mk(0, 0, 4'd9, 0, 0,  0, 0, 0, 1, 0, 8'h00, 0, 2)); // len 9 invalid
        tbl.push_back(mk(0, 0, 4'd7, 0, 1,  0, 0, 0, 1, 0, 8'hFF, 0, 2)); // ack ignored
        tbl.push_back(mk(0, 0, 4'd15, 1, 0, 0, 0, 0, 1, 0, 8'h00, 0, 2)); // invalid eop word
        tbl.push_back(mk(0, 0, 4'd3, 1, 0,  0, 0, 0, 0, 0, 8'h00, 0, 3)); // IFG
        tbl.push_back(mk(0, 0, 4'd3, 1, 0,  0, 0, 0, 0, 0, 8'h00, 0, 3)); // idle

        do_reset();

        // Directed table, IFG_CYCLES = 1.
        req0_data = D0; req1_data = D1; req1_len = 4'd7; req1_eop = 1'b1;
        foreach (tbl[i]) begin
            v = tbl[i];
            req0_pkt_avail = v.a0; req1_pkt_avail = v.a1;
            req0_len = v.l0; req0_eop = v.e0; tx_ack = v.ack;
            #3;
            chk($sformatf("tbl%0d tx_start", i), tx_start, v.st);
            chk($sformatf("tbl%0d pkt_ack0", i), req0_pkt_ack, v.pa0);
            chk($sformatf("tbl%0d pkt_ack1", i), req1_pkt_ack, v.pa1);
            chk($sformatf("tbl%0d rd_en0", i), req0_rd_en, v.rd0);
            chk($sformatf("tbl%0d rd_en1", i), req1_rd_en, v.rd1);
            chk($sformatf("tbl%0d valid", i), tx_data_valid, v.dv);
            chk($sformatf("tbl%0d grant_id", i), grant_id, v.gid);
            chk($sformatf("tbl%0d count", i), tx_pkt_count, v.cnt);
            if (v.rd0 || v.rd1)
                chk($sformatf("tbl%0d tx_data", i), tx_data, v.rd1 ? D1 : D0);
            tick();
        end

        // Delayed ack: 4 WAIT_ACK cycles, then a 4-word req0 packet.
        dmask = '{8'hFF, 8'hFF, 8'hFF, 8'h07};
        req0_pkt_avail = 1; req1_pkt_avail = 0; req0_len = 4'd7; req0_eop = 0; tx_ack = 0;
        #3;
        chk("dly start", tx_start, 1'b1);
        chk("dly ack0", req0_pkt_ack, 1'b1);
        tick();
        req0_pkt_avail = 0;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk("dly wait valid", tx_data_valid, 8'h00);
            chk("dly wait rd0", req0_rd_en, 1'b0);
            tick();
        end
        for (int w = 0; w < 4; w++) begin
            req0_len = (w == 3) ? 4'd2 : 4'd7;
            req0_eop = (w == 3);
            tx_ack = (w == 0);
            #3;
            chk($sformatf("dly word%0d valid", w), tx_data_valid, dmask[w]);
            chk($sformatf("dly word%0d rd0", w), req0_rd_en, 1'b1);
            tick();
        end
        #3;
        chk("dly count", tx_pkt_count, 32'd4);
        chk("dly ifg valid", tx_data_valid, 8'h00);
        tick();

        // Back-to-back single-word req0 packets with immediate ack: a new
        // tx_start every IFG+2 cycles on each instance.
        do_reset();
        req0_pkt_avail = 1; req0_len = 4'd0; req0_eop = 1; tx_ack = 1; req0_data = D0;
        for (int k = 0; k < 15; k++) begin
            #3;
            chk($sformatf("ifg1 start k%0d", k), tx_start, (k % 3) == 0);
            chk($sformatf("ifg0 start k%0d", k), g0_start, (k % 2) == 0);
            chk($sformatf("ifg3 start k%0d", k), g3_start, (k % 5) == 0);
            tick();
        end
        #3;
        chk("ifg1 count", tx_pkt_count, 32'd5);
        chk("ifg3 count", g3_cnt, 32'd3);

        // Reset in word 2 of a 6-word req0 packet.
        tick();
        do_reset();
        req0_pkt_avail = 1; req0_len = 4'd7; req0_eop = 0; tx_ack = 0;
        tick();
        req0_pkt_avail = 0; tx_ack = 1;
        tick();
        tx_ack = 0;
        #3;
        chk("rst word2 rd0", req0_rd_en, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #3;
        chk("rst valid", tx_data_valid, 8'h00);
        chk("rst rd0", req0_rd_en, 1'b0);
        chk("rst start", tx_start, 1'b0);
        chk("rst count", tx_pkt_count, 32'd0);
        chk("rst grant_id", grant_id, 1'b1);
        tick();
        req0_pkt_avail = 1; req1_pkt_avail = 1;
        #3;
        chk("rst first ack0", req0_pkt_ack, 1'b1);
        chk("rst first ack1", req1_pkt_ack, 1'b0);
        tick();

        // Randomized traffic against the transaction-level reference model.
        do_reset();
        busy = 0; acked = 0; mgid = 1; mcnt = 0; next_ok = 0;
        for (int t = 0; t < 3000; t++) begin
            if (t < 2700 && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    if (np0 < 4) push_pkt(0);
                end else begin
                    if (np1 < 4) push_pkt(1);
                end
            end
            tx_ack = ($urandom_range(0, 2) == 0);
            drive_heads();
            #3;
            chk("rnd count", tx_pkt_count, 32'(mcnt));
            chk("rnd grant_id", grant_id, mgid);
            if (!busy) begin
                exp_st = (t >= next_ok) && (req0_pkt_avail || req1_pkt_avail);
                win = (req0_pkt_avail && req1_pkt_avail) ? !mgid : req1_pkt_avail;
                chk("rnd idle start", tx_start, exp_st);
                chk("rnd idle ack0", req0_pkt_ack, exp_st && !win);
                chk("rnd idle ack1", req1_pkt_ack, exp_st && win);
                chk("rnd idle valid", tx_data_valid, 8'h00);
                chk("rnd idle rd", {req0_rd_en, req1_rd_en}, 2'b00);
                if (exp_st) begin
                    busy = 1; acked = 0; mgid = win;
                end
            end else if (!acked && !tx_ack) begin
                chk("rnd wait start", tx_start, 1'b0);
                chk("rnd wait ack", {req0_pkt_ack, req1_pkt_ack}, 2'b00);
                chk("rnd wait valid", tx_data_valid, 8'h00);
                chk("rnd wait rd", {req0_rd_en, req1_rd_en}, 2'b00);
            end else begin
                acked = 1;
                chk("rnd head present", (mgid ? q1.size() : q0.size()) > 0, 1'b1);
                if ((mgid ? q1.size() : q0.size()) == 0) begin
                    busy = 0;
                end else begin
                    hw = mgid ? q1[0] : q0[0];
                    chk("rnd tx_data", tx_data, hw.d);
                    chk("rnd valid", tx_data_valid, model_mask(hw.l));
                    chk("rnd rd0", req0_rd_en, !mgid);
                    chk("rnd rd1", req1_rd_en, mgid);
                    chk("rnd send start", tx_start, 1'b0);
                    chk("rnd send ack", {req0_pkt_ack, req1_pkt_ack}, 2'b00);
                    if (hw.e) begin
                        busy = 0; mcnt++; next_ok = t + IFG + 1;
                    end
                end
            end
            s_rd0 = req0_rd_en; s_rd1 = req1_rd_en;
            s_pa0 = req0_pkt_ack; s_pa1 = req1_pkt_ack;
            tick();
            if (s_rd0 && q0.size() > 0) q0.delete(0);
            if (s_rd1 && q1.size() > 0) q1.delete(0);
            if (s_pa0 && np0 > 0) np0--;
            if (s_pa1 && np1 > 0) np1--;
        end
        chk("rnd drained q0", q0.size(), 0);
        chk("rnd drained q1", q1.size(), 0);
        chk("rnd final count", tx_pkt_count, 32'(mcnt));

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
